// File: rtl/mem_write_pingpong.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_write_pingpong                                                         |
// | N-lane banked BRAM write controller with ping-pong frame buffers.          |
// | Optional: define MEM_WRITE_OUT_REG_EN to register the BRAM write outputs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_write_pingpong #(
   parameter int D_W   = 8,
   parameter int N     = 3,
   parameter int M     = 6,
   parameter int DEPTH = (M*M)/N,
   parameter int AW    = $clog2(DEPTH)+1,
   parameter int LW    = $clog2(DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LW-1:0]      cfg_len,
   input  logic [N-1:0]       in_valid,
   input  logic [N*D_W-1:0]   in_data,
   output logic [N-1:0]       in_ready,
   output logic [N*AW-1:0]    wr_addr_bram,
   output logic [N*D_W-1:0]   wr_data_bram,
   output logic [N-1:0]       wr_en_bram,
   output logic               frame_done,
   output logic               frame_buf,
   input  logic               buf_release,
   output logic [1:0]         buf_full
);

   localparam int CW = AW-1;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0][CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]         lane_done_q, lane_done_d;
   logic                 wbuf_q, wbuf_d;
   logic [1:0]           buf_full_q, buf_full_d;
   logic                 frame_done_q, frame_done_d;
   logic                 frame_buf_q, frame_buf_d;
   logic [LW-1:0]        len_q, len_d;

   logic [N-1:0]         ready;
   logic [N-1:0]         accept;
   logic [N-1:0]         finish;
   logic [LW-1:0]        len_last;
   logic [LW-1:0]        cfg_len_eff;
   logic                 idle;
   logic                 close;
   logic                 release_ok;

   always_comb begin
      // Reset must block acceptance immediately, not at the next edge.
      ready = '0;
      if (rst_n && (state_q == FILL)) begin
         ready = ~lane_done_q;
      end
      accept   = in_valid & ready;
      len_last = len_q - LW'(1);

      finish = '0;
      for (int x = 0; x < N; x++) begin
         finish[x] = accept[x] && (LW'(cnt_q[x]) == len_last);
      end

      close       = &(lane_done_q | finish);
      idle        = (cnt_q == '0) && (lane_done_q == '0) && (accept == '0);
      release_ok  = buf_release && (buf_full_q != 2'd0);
      cfg_len_eff = ((cfg_len == '0) || (cfg_len > LW'(DEPTH))) ? LW'(DEPTH) : cfg_len;
   end

   always_comb begin
      cnt_d       = cnt_q;
      lane_done_d = lane_done_q;
      len_d       = idle ? cfg_len_eff : len_q;

      for (int x = 0; x < N; x++) begin
         if (accept[x]) begin
            if (finish[x]) begin
               cnt_d[x]       = '0;
               lane_done_d[x] = 1'b1;
            end else begin
               cnt_d[x] = cnt_q[x] + CW'(1);
            end
         end
      end

      if (close) begin
         lane_done_d = '0;
      end

      frame_done_d = close;
      frame_buf_d  = close ? wbuf_q : frame_buf_q;
      wbuf_d       = wbuf_q ^ close;
      buf_full_d   = buf_full_q + {1'b0, close} - {1'b0, release_ok};

      state_d = state_q;
      case (state_q)
         FILL:    if (buf_full_d == 2'd2) state_d = STALL;
         STALL:   if (buf_release)        state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         lane_done_q  <= '0;
         wbuf_q       <= 1'b0;
         buf_full_q   <= 2'd0;
         frame_done_q <= 1'b0;
         frame_buf_q  <= 1'b0;
         len_q        <= LW'(DEPTH);
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lane_done_q  <= lane_done_d;
         wbuf_q       <= wbuf_d;
         buf_full_q   <= buf_full_d;
         frame_done_q <= frame_done_d;
         frame_buf_q  <= frame_buf_d;
         len_q        <= len_d;
      end
   end

   logic [N*AW-1:0] wr_addr_c;

   for (genvar x = 0; x < N; x++) begin : g_lane
      assign wr_addr_c[x*AW +: AW] = {wbuf_q, cnt_q[x]};
   end

`ifdef MEM_WRITE_OUT_REG_EN
   logic [N*AW-1:0]  wr_addr_q;
   logic [N*D_W-1:0] wr_data_q;
   logic [N-1:0]     wr_en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= '0;
      end else begin
         wr_addr_q <= wr_addr_c;
         wr_data_q <= in_data;
         wr_en_q   <= accept;
      end
   end

   assign wr_addr_bram = wr_addr_q;
   assign wr_data_bram = wr_data_q;
   assign wr_en_bram   = wr_en_q;
`else
   assign wr_addr_bram = wr_addr_c;
   assign wr_data_bram = in_data;
   assign wr_en_bram   = accept;
`endif

   assign in_ready   = ready;
   assign frame_done = frame_done_q;
   assign frame_buf  = frame_buf_q;
   assign buf_full   = buf_full_q;

endmodule
`default_nettype wire
